// File: rtl/pipe_ctrl_fsm_pkg.sv
// Shared types and constants for the pipeline controller (package ctrl_pkg).
package ctrl_pkg;
  localparam int NUM_RET            = 3;
  localparam int RET_IDX_W          = (NUM_RET > 1) ? $clog2(NUM_RET) : 1;
  localparam int RECOVER_CYCLES_DEF = 2;

  typedef enum logic [1:0] {RUN, FLUSH, RECOVER} ctrl_state_t;
endpackage

// File: rtl/pipe_ctrl_fsm_if.sv
// Core-side signal bundle of the pipeline controller; slave = controller, master = core.
interface pipe_ctrl_fsm_if;
  import ctrl_pkg::*;

  logic               full_PRF, full_ROB, full_FIFO, full_RS_add, full_RS_mul, full_RS_agu, full_LSQ;
  logic [NUM_RET-1:0] ready_ret;
  logic [NUM_RET-1:0] excep_ret;
  logic [NUM_RET-1:0] retire_en;
  logic               flush;
  logic               arat_restore;
  logic               freeze_front;
  logic               freeze_back;
  logic [1:0]         exc_slot;
  logic [31:0]        perf_stall_cyc;
  logic [15:0]        perf_flush_cnt;

  modport master (
    output full_PRF, full_ROB, full_FIFO, full_RS_add, full_RS_mul, full_RS_agu, full_LSQ,
    output ready_ret, excep_ret,
    input  retire_en, flush, arat_restore, freeze_front, freeze_back, exc_slot,
    input  perf_stall_cyc, perf_flush_cnt
  );

  modport slave (
    input  full_PRF, full_ROB, full_FIFO, full_RS_add, full_RS_mul, full_RS_agu, full_LSQ,
    input  ready_ret, excep_ret,
    output retire_en, flush, arat_restore, freeze_front, freeze_back, exc_slot,
    output perf_stall_cyc, perf_flush_cnt
  );
endinterface

// File: rtl/pipe_ctrl_fsm_ret_prio_scan.sv
// In-order retirement scan: commit mask up to the first non-ready or excepting slot,
// plus the index of the oldest excepting slot.
module ret_prio_scan
  import ctrl_pkg::*;
(
  input  logic [NUM_RET-1:0]   ready_ret,
  input  logic [NUM_RET-1:0]   excep_ret,
  output logic [NUM_RET-1:0]   ok,
  output logic                 exc_hit,
  output logic [RET_IDX_W-1:0] exc_idx
);

  always_comb begin
    logic prev;
    ok      = '0;
    exc_hit = 1'b0;
    exc_idx = '0;
    prev    = 1'b1;
    for (int i = 0; i < NUM_RET; i++) begin
      // prev gates everything younger, so at most one slot can hit
      if (prev && ready_ret[i] && excep_ret[i]) begin
        exc_hit = 1'b1;
        exc_idx = RET_IDX_W'(i);
      end
      ok[i] = prev & ready_ret[i] & ~excep_ret[i];
      prev  = ok[i];
    end
  end

endmodule

// File: rtl/pipe_ctrl_fsm.sv
// Pipeline controller: retire enables, exception flush and timed ARAT recovery.
// Optional saturating performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter int RECOVER_CYCLES = RECOVER_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  pipe_ctrl_fsm_if.slave    bus
);

  // state   | meaning
  // RUN     | normal operation, retire scan active, freeze_front follows full flags
  // FLUSH   | one-cycle flush + ARAT restore pulse, all stages frozen
  // RECOVER | RECOVER_CYCLES cycles of ARAT copy, all stages frozen

  localparam int CNT_W = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES + 1) : 1;

  ctrl_state_t          state;
  logic [CNT_W-1:0]     cnt;
  logic                 flush_q, arat_q;
  logic [1:0]           exc_slot_q;
  logic [NUM_RET-1:0]   ok;
  logic                 exc_hit;
  logic [RET_IDX_W-1:0] exc_idx;
  logic                 any_full;
  logic                 freeze_front;
  logic                 flush_entry;

  ret_prio_scan u_scan (
    .ready_ret (bus.ready_ret),
    .excep_ret (bus.excep_ret),
    .ok        (ok),
    .exc_hit   (exc_hit),
    .exc_idx   (exc_idx)
  );

  assign any_full = bus.full_PRF | bus.full_ROB | bus.full_FIFO | bus.full_RS_add |
                    bus.full_RS_mul | bus.full_RS_agu | bus.full_LSQ;
  assign flush_entry  = (state == RUN) && exc_hit;
  assign freeze_front = (state == RUN) ? any_full : 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      cnt        <= '0;
      flush_q    <= 1'b0;
      arat_q     <= 1'b0;
      exc_slot_q <= '0;
    end else begin
      flush_q <= 1'b0;
      arat_q  <= 1'b0;
      case (state)
        RUN: begin
          if (exc_hit) begin
            state      <= FLUSH;
            flush_q    <= 1'b1;
            arat_q     <= 1'b1;
            exc_slot_q <= 2'(exc_idx);
          end
        end
        FLUSH: begin
          state <= RECOVER;
          cnt   <= CNT_W'(RECOVER_CYCLES);
        end
        RECOVER: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

  // retire is suppressed while rst is held so nothing commits during reset
  assign bus.retire_en    = (state == RUN && !rst) ? ok : '0;
  assign bus.flush        = flush_q;
  assign bus.arat_restore = arat_q;
  assign bus.freeze_front = freeze_front;
  assign bus.freeze_back  = (state != RUN);
  assign bus.exc_slot     = exc_slot_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cyc;
  logic [15:0] flush_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cyc <= '0;
      flush_cnt <= '0;
    end else begin
      if (freeze_front && stall_cyc != '1) stall_cyc <= stall_cyc + 1'b1;
      if (flush_entry && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
    end
  end

  assign bus.perf_stall_cyc = stall_cyc;
  assign bus.perf_flush_cnt = flush_cnt;
`else
  logic unused_perf;
  assign unused_perf        = flush_entry;
  assign bus.perf_stall_cyc = '0;
  assign bus.perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl_fsm.sv
// Randomized bench for pipe_ctrl_fsm against a cycle-count reference model.
module tb_pipe_ctrl_fsm;
  import ctrl_pkg::*;

  localparam int RC = RECOVER_CYCLES_DEF;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_ctrl_fsm_if bus ();

  pipe_ctrl_fsm #(.RECOVER_CYCLES(RC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec  = 0;
  int n_miss = 0;

  // model: cycles until back in RUN (0 = RUN, RC+1 = flush cycle)
  int          m_left;
  int          m_exc_slot;
  longint      m_stall;
  int          m_flushes;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_vec++;
    if (obs != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int first_stop(input logic [NUM_RET-1:0] rdy, input logic [NUM_RET-1:0] exc);
    for (int i = 0; i < NUM_RET; i++)
      if (!(rdy[i] && !exc[i])) return i;
    return NUM_RET;
  endfunction

  task automatic drive(input logic r, input logic [6:0] full,
                       input logic [NUM_RET-1:0] rdy, input logic [NUM_RET-1:0] exc);
    rst = r;
    {bus.full_PRF, bus.full_ROB, bus.full_FIFO, bus.full_RS_add,
     bus.full_RS_mul, bus.full_RS_agu, bus.full_LSQ} = full;
    bus.ready_ret = rdy;
    bus.excep_ret = exc;
  endtask

  // one cycle: drive, compare mid-cycle, advance model at the edge
  task automatic cycle(input logic r, input logic [6:0] full,
                       input logic [NUM_RET-1:0] rdy, input logic [NUM_RET-1:0] exc);
    int  stop;
    int  exp_ret;
    bit  exp_ff;
    bit  exc_now;
    drive(r, full, rdy, exc);
    @(negedge clk);
    stop    = first_stop(rdy, exc);
    exc_now = (stop < NUM_RET) && rdy[stop] && exc[stop];
    exp_ret = (r || m_left != 0) ? 0 : ((1 << stop) - 1);
    exp_ff  = (m_left != 0) ? 1'b1 : (full != 0);
    check("retire_en",    bus.retire_en,    exp_ret);
    check("flush",        bus.flush,        m_left == RC + 1);
    check("arat_restore", bus.arat_restore, m_left == RC + 1);
    check("freeze_front", bus.freeze_front, exp_ff);
    check("freeze_back",  bus.freeze_back,  m_left != 0);
    check("exc_slot",     bus.exc_slot,     m_exc_slot);
`ifdef PIPE_CTRL_PERF_EN
    check("perf_stall_cyc", bus.perf_stall_cyc, m_stall);
    check("perf_flush_cnt", bus.perf_flush_cnt, m_flushes);
`else
    check("perf_stall_cyc", bus.perf_stall_cyc, 0);
    check("perf_flush_cnt", bus.perf_flush_cnt, 0);
`endif
    @(posedge clk);
    if (r) begin
      m_left = 0; m_exc_slot = 0; m_stall = 0; m_flushes = 0;
    end else begin
      if (exp_ff && m_stall < 64'hFFFF_FFFF) m_stall++;
      if (m_left == 0 && exc_now) begin
        m_left     = RC + 1;
        m_exc_slot = stop;
        if (m_flushes < 16'hFFFF) m_flushes++;
      end else if (m_left > 0) begin
        m_left--;
      end
    end
    #1;
  endtask

  initial begin
    m_left = 0; m_exc_slot = 0; m_stall = 0; m_flushes = 0;
    drive(1'b1, 7'h00, '0, '0);
    @(posedge clk);
    #1;

    // reset with random inputs
    repeat (2) cycle(1'b1, 7'($urandom), 3'($urandom), 3'($urandom));

    // structural stall
    repeat (5) cycle(1'b0, 7'b0100000, '0, '0);

    // partial retire
    cycle(1'b0, 7'h00, 3'b011, 3'b000);
    cycle(1'b0, 7'h00, 3'b101, 3'b000);

    // exception in slot 1, then ride through recovery
    cycle(1'b0, 7'h00, 3'b111, 3'b010);
    repeat (RC + 2) cycle(1'b0, 7'h00, 3'b111, 3'b000);

    // masked exception, then exception with a second one injected during recovery
    cycle(1'b0, 7'h00, 3'b101, 3'b100);
    cycle(1'b0, 7'h01, 3'b111, 3'b101);
    cycle(1'b0, 7'h00, 3'b111, 3'b111);
    repeat (RC) cycle(1'b0, 7'h00, 3'b111, 3'b111);
    repeat (2) cycle(1'b0, 7'h00, 3'b000, 3'b000);

    // reset in the first recovery cycle
    cycle(1'b0, 7'h00, 3'b001, 3'b001);
    cycle(1'b0, 7'h00, 3'b000, 3'b000);
    cycle(1'b1, 7'h00, 3'b000, 3'b000);
    repeat (3) cycle(1'b0, 7'h00, 3'b011, 3'b000);

    // random traffic
    for (int k = 0; k < 3000; k++) begin
      logic [6:0]         f;
      logic [NUM_RET-1:0] rd, ex;
      f  = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'h00;
      rd = 3'($urandom);
      ex = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'b000;
      cycle($urandom_range(0, 199) == 0, f, rd, ex);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
